// File: rtl/line_sched_pkg.sv
// Shared constants and FSM state encoding for the line convolution scheduler.
package line_sched_pkg;

  localparam int KSIZE       = 3;
  localparam int NUM_CHANNEL = 3;
  localparam int NUM_KERNEL  = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } sched_state_t;

endpackage

// File: rtl/sched_beat_counter.sv
// Wrapping beat counter: o_tc flags the accepted beat that completes i_limit beats.
module sched_beat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  assign o_tc = i_en && (r_cnt == (i_limit - W'(1)));

  // Self-wraps on terminal count so each pass starts from zero without a reload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : (r_cnt + W'(1));
    end
  end

endmodule

// File: rtl/line_conv_scheduler.sv
// Sequences weight-load / stream / drain passes over (kngrp, chgrp) for a line conv engine.
// Optional stall counter enabled by defining LINE_SCHED_PERF_CNT_EN.
module line_conv_scheduler #(
  parameter int KSIZE     = line_sched_pkg::KSIZE,
  parameter int CNT_WIDTH = 16,
  parameter int PIPE_LAT  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [CNT_WIDTH-1:0] i_cfg_width,
  input  logic [7:0]           i_cfg_num_chgrp,
  input  logic [7:0]           i_cfg_num_kngrp,
  output logic                 o_weight_req,
  input  logic                 i_weight_val,
  output logic                 o_data_req,
  input  logic                 i_data_val,
  output logic                 o_psum_first,
  output logic                 o_psum_last,
  output logic [7:0]           o_chgrp_idx,
  output logic [7:0]           o_kngrp_idx,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [31:0]          o_stall_cnt
);

  import line_sched_pkg::*;

  sched_state_t         r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_width;
  logic [CNT_WIDTH-1:0] r_drain;
  logic [7:0]           r_num_ch, r_num_kn, r_ch, r_kn;
  logic                 r_err;

  logic w_start_ok, w_cfg_bad, w_wbeat, w_dbeat, w_w_tc, w_d_tc;
  logic w_drain_end, w_ch_wrap, w_kn_wrap;

  assign w_start_ok  = (r_state == S_IDLE) && i_start;
  assign w_cfg_bad   = (i_cfg_width < CNT_WIDTH'(KSIZE)) ||
                       (i_cfg_num_chgrp == 8'd0) || (i_cfg_num_kngrp == 8'd0);
  assign w_wbeat     = (r_state == S_LOAD_W) && i_weight_val;
  assign w_dbeat     = (r_state == S_STREAM) && i_data_val;
  assign w_drain_end = (r_state == S_DRAIN) && (r_drain == CNT_WIDTH'(PIPE_LAT - 1));
  assign w_ch_wrap   = (r_ch == (r_num_ch - 8'd1));
  assign w_kn_wrap   = (r_kn == (r_num_kn - 8'd1));

  assign o_weight_req = (r_state == S_LOAD_W);
  assign o_data_req   = (r_state == S_STREAM);
  assign o_chgrp_idx  = r_ch;
  assign o_kngrp_idx  = r_kn;
  assign o_err        = r_err;

  sched_beat_counter #(.W(CNT_WIDTH)) u_weight_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_start_ok),
    .i_en    (w_wbeat),
    .i_limit (CNT_WIDTH'(KSIZE)),
    .o_tc    (w_w_tc)
  );

  sched_beat_counter #(.W(CNT_WIDTH)) u_data_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_start_ok),
    .i_en    (w_dbeat),
    .i_limit (r_width),
    .o_tc    (w_d_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_busy       = (r_state != S_IDLE);
    o_done       = 1'b0;
    o_psum_first = 1'b0;
    o_psum_last  = 1'b0;
    case (r_state)
      S_IDLE:   if (i_start) w_state_nxt = w_cfg_bad ? S_DONE : S_LOAD_W;
      S_LOAD_W: if (w_w_tc) w_state_nxt = S_STREAM;
      S_STREAM: begin
        o_psum_first = (r_ch == 8'd0);
        o_psum_last  = w_ch_wrap;
        if (w_d_tc) w_state_nxt = S_DRAIN;
      end
      S_DRAIN:  if (w_drain_end) w_state_nxt = (w_ch_wrap && w_kn_wrap) ? S_DONE : S_LOAD_W;
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Error pulses for a rejected config or for a start arriving mid-job.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err    <= 1'b0;
      r_width  <= '0;
      r_num_ch <= 8'd0;
      r_num_kn <= 8'd0;
      r_ch     <= 8'd0;
      r_kn     <= 8'd0;
      r_drain  <= '0;
    end else begin
      r_err <= i_start && ((r_state != S_IDLE) || w_cfg_bad);
      if (w_start_ok) begin
        r_width  <= i_cfg_width;
        r_num_ch <= i_cfg_num_chgrp;
        r_num_kn <= i_cfg_num_kngrp;
        r_ch     <= 8'd0;
        r_kn     <= 8'd0;
      end
      if (r_state == S_DRAIN) begin
        r_drain <= w_drain_end ? '0 : (r_drain + CNT_WIDTH'(1));
      end
      if (w_drain_end) begin
        if (w_ch_wrap) begin
          r_ch <= 8'd0;
          r_kn <= w_kn_wrap ? 8'd0 : (r_kn + 8'd1);
        end else begin
          r_ch <= r_ch + 8'd1;
        end
      end
    end
  end

`ifdef LINE_SCHED_PERF_CNT_EN
  logic [31:0] r_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall <= 32'd0;
    end else if (w_start_ok) begin
      r_stall <= 32'd0;
    end else if (((o_weight_req && !i_weight_val) || (o_data_req && !i_data_val)) &&
                 (r_stall != 32'hFFFF_FFFF)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall;
`else
  assign o_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_line_conv_scheduler.sv
// Scoreboard bench for line_conv_scheduler: per-pass expectations queued at job start.
module tb_line_conv_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [15:0] i_cfg_width;
  logic [7:0]  i_cfg_num_chgrp, i_cfg_num_kngrp;
  logic        o_weight_req, i_weight_val, o_data_req, i_data_val;
  logic        o_psum_first, o_psum_last;
  logic [7:0]  o_chgrp_idx, o_kngrp_idx;
  logic        o_busy, o_done, o_err;
  logic [31:0] o_stall_cnt;

  typedef struct {
    logic [7:0] kn;
    logic [7:0] ch;
    logic       first;
    logic       last;
    int         beats;
  } pass_t;

  pass_t exp_q[$];
  pass_t sb_e;
  int    n_chk = 0;
  int    n_err = 0;
  int    wbeats = 0;
  int    dbeats = 0;
  logic       m_in_pass = 1'b0, m_first = 1'b0, m_last = 1'b0;
  logic [7:0] m_kn = 8'd0, m_ch = 8'd0;
  int         m_beats = 0;

  always #5 clk = ~clk;

  line_conv_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .i_start         (i_start),
    .i_cfg_width     (i_cfg_width),
    .i_cfg_num_chgrp (i_cfg_num_chgrp),
    .i_cfg_num_kngrp (i_cfg_num_kngrp),
    .o_weight_req    (o_weight_req),
    .i_weight_val    (i_weight_val),
    .o_data_req      (o_data_req),
    .i_data_val      (i_data_val),
    .o_psum_first    (o_psum_first),
    .o_psum_last     (o_psum_last),
    .o_chgrp_idx     (o_chgrp_idx),
    .o_kngrp_idx     (o_kngrp_idx),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_err           (o_err),
    .o_stall_cnt     (o_stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Pass monitor: a pass ends on the first sample with o_data_req low.
  always @(negedge clk) begin
    if (!rst) begin
      m_in_pass <= 1'b0;
      m_beats   <= 0;
      m_first   <= 1'b0;
      m_last    <= 1'b0;
    end else begin
      if (o_weight_req && i_weight_val) wbeats <= wbeats + 1;
      if (o_data_req) begin
        m_in_pass <= 1'b1;
        m_kn      <= o_kngrp_idx;
        m_ch      <= o_chgrp_idx;
        m_first   <= m_first | o_psum_first;
        m_last    <= m_last | o_psum_last;
        if (i_data_val) begin
          m_beats <= m_beats + 1;
          dbeats  <= dbeats + 1;
        end
      end else if (m_in_pass) begin
        m_in_pass <= 1'b0;
        m_beats   <= 0;
        m_first   <= 1'b0;
        m_last    <= 1'b0;
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_pass", 32'd1, 32'd0);
        end else begin
          sb_e = exp_q.pop_front();
          chk("sb_kn", {24'd0, m_kn}, {24'd0, sb_e.kn});
          chk("sb_ch", {24'd0, m_ch}, {24'd0, sb_e.ch});
          chk("sb_beats", m_beats, sb_e.beats);
          chk("sb_first", {31'd0, m_first}, {31'd0, sb_e.first});
          chk("sb_last", {31'd0, m_last}, {31'd0, sb_e.last});
        end
      end
    end
  end

  task automatic start_job(input int w, input int nch, input int nkn, input bit push);
    i_cfg_width     = 16'(w);
    i_cfg_num_chgrp = 8'(nch);
    i_cfg_num_kngrp = 8'(nkn);
    if (push) begin
      for (int k = 0; k < nkn; k++) begin
        for (int c = 0; c < nch; c++) begin
          exp_q.push_back('{kn: 8'(k), ch: 8'(c), first: (c == 0), last: (c == nch - 1), beats: w});
        end
      end
    end
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!o_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, {31'd0, o_done}, 32'd1);
    @(negedge clk);
    chk({tag, "_idle"}, {31'd0, o_busy}, 32'd0);
    chk({tag, "_sb_left"}, exp_q.size(), 32'd0);
  endtask

  function automatic logic [5:0] t1_exp(input int n);
    // {weight_req, data_req, psum_first, psum_last, busy, done}
    if (n <= 3)       return 6'b100010;
    else if (n <= 8)  return 6'b011110;
    else if (n <= 10) return 6'b000010;
    else if (n == 11) return 6'b000011;
    else              return 6'b000000;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0, n;
    rst = 1'b0; i_start = 1'b0; i_weight_val = 1'b1; i_data_val = 1'b1;
    i_cfg_width = 16'd0; i_cfg_num_chgrp = 8'd0; i_cfg_num_kngrp = 8'd0;
    #3;
    chk("rst_ctl", {25'd0, o_weight_req, o_data_req, o_psum_first, o_psum_last, o_busy, o_done, o_err}, 32'd0);
    chk("rst_idx", {16'd0, o_kngrp_idx, o_chgrp_idx}, 32'd0);
    chk("rst_stall", o_stall_cnt, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    // Single pass, exact cycle trace.
    start_job(5, 1, 1, 1);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk($sformatf("t1_cyc%0d", c),
          {26'd0, o_weight_req, o_data_req, o_psum_first, o_psum_last, o_busy, o_done},
          {26'd0, t1_exp(c)});
    end
    chk("t1_sb_left", exp_q.size(), 32'd0);
    chk("t1_stall", o_stall_cnt, 32'd0);

    // Four passes in (kn, ch) order.
    w0 = wbeats; d0 = dbeats;
    start_job(4, 2, 2, 1);
    wait_done("t2");
    chk("t2_wbeats", wbeats - w0, 32'd12);
    chk("t2_dbeats", dbeats - d0, 32'd16);

    // Alternating data valid.
    d0 = dbeats;
    i_data_val = 1'b1;
    start_job(4, 1, 1, 1);
    n = 0;
    while (!o_data_req && n < 200) begin @(negedge clk); n++; end
    chk("t3_stream_seen", {31'd0, o_data_req}, 32'd1);
    n = 0;
    while (n < 200) begin
      @(posedge clk); #1 i_data_val = ~i_data_val;
      @(negedge clk);
      n++;
      if (!o_data_req) break;
    end
    i_data_val = 1'b1;
    wait_done("t3");
    chk("t3_dbeats", dbeats - d0, 32'd4);
`ifdef LINE_SCHED_PERF_CNT_EN
    chk("t3_stall", o_stall_cnt, 32'd3);
`else
    chk("t3_stall", o_stall_cnt, 32'd0);
`endif

    // Bad config: width below kernel size.
    w0 = wbeats; d0 = dbeats;
    start_job(2, 1, 1, 0);
    @(negedge clk);
    chk("t4_err_cyc", {27'd0, o_weight_req, o_data_req, o_done, o_err, o_busy}, 32'b00111);
    @(negedge clk);
    chk("t4_after", {27'd0, o_weight_req, o_data_req, o_done, o_err, o_busy}, 32'd0);
    chk("t4_no_beats", (wbeats - w0) + (dbeats - d0), 32'd0);

    // Asynchronous reset mid-stream of pass (kn1, ch?).
    start_job(5, 2, 2, 1);
    n = 0;
    while (!(o_data_req && o_kngrp_idx == 8'd1) && n < 500) begin @(negedge clk); n++; end
    chk("t5_reach_kn1", {31'd0, o_data_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_ctl", {25'd0, o_weight_req, o_data_req, o_psum_first, o_psum_last, o_busy, o_done, o_err}, 32'd0);
    chk("t5_rst_idx", {16'd0, o_kngrp_idx, o_chgrp_idx}, 32'd0);
    chk("t5_rst_stall", o_stall_cnt, 32'd0);
    exp_q.delete();
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_stay_idle", {30'd0, o_busy, o_weight_req}, 32'd0);
    start_job(3, 1, 2, 1);
    wait_done("t5");

    // Stray start during LOAD_W.
    w0 = wbeats; d0 = dbeats;
    start_job(4, 2, 1, 1);
    n = 0;
    while (!o_weight_req && n < 200) begin @(negedge clk); n++; end
    chk("t6_in_load", {31'd0, o_weight_req}, 32'd1);
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    @(negedge clk);
    chk("t6_err", {31'd0, o_err}, 32'd1);
    chk("t6_still_busy", {31'd0, o_busy}, 32'd1);
    @(negedge clk);
    chk("t6_err_clr", {31'd0, o_err}, 32'd0);
    wait_done("t6");
    chk("t6_wbeats", wbeats - w0, 32'd6);
    chk("t6_dbeats", dbeats - d0, 32'd8);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/line_conv_scheduler.md
LINE_CONV_SCHEDULER -- requirements
Module: line_conv_scheduler

Interface
REQ-001 SHALL have parameter KSIZE, default 3: kernel row positions, one weight beat per position.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of line-width and beat counters.
REQ-003 SHALL have parameter PIPE_LAT, default 2: engine drain cycles after the last data beat.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port i_start, input, 1: job start pulse.
REQ-007 SHALL have port i_cfg_width, input, CNT_WIDTH: pixels per input line.
REQ-008 SHALL have port i_cfg_num_chgrp, input, 8: 3-channel groups per job.
REQ-009 SHALL have port i_cfg_num_kngrp, input, 8: 4-kernel groups per job.
REQ-010 SHALL have ports o_weight_req output 1 and i_weight_val input 1: weight beat handshake.
REQ-011 SHALL have ports o_data_req output 1 and i_data_val input 1: activation beat handshake.
REQ-012 SHALL have ports o_psum_first and o_psum_last, outputs, 1 each: engine zeroes psum / emits final psum.
REQ-013 SHALL have ports o_chgrp_idx and o_kngrp_idx, outputs, 8 each: current pass indices.
REQ-014 SHALL have ports o_busy, o_done and o_err, outputs, 1 each: job status.
REQ-015 SHALL have port o_stall_cnt, output, 32: stall cycle count.

Function
REQ-016 SHALL implement states IDLE, LOAD_W, STREAM, DRAIN, DONE.
REQ-017 SHALL, in IDLE, on i_start: latch config; enter LOAD_W next cycle with indices cleared.
REQ-018 SHALL, on a bad config (width<KSIZE, chgrp=0 or kngrp=0), go IDLE->DONE, pulse o_err one cycle, raise no requests.
REQ-019 SHALL drive o_weight_req=(state==LOAD_W) and o_data_req=(state==STREAM).
REQ-020 SHALL count a beat only when req and val are both high; val with req low is ignored.
REQ-021 SHALL leave LOAD_W for STREAM the cycle after the KSIZE-th weight beat.
REQ-022 SHALL leave STREAM for DRAIN the cycle after the width-th data beat.
REQ-023 SHALL stay in DRAIN exactly PIPE_LAT cycles.
REQ-024 SHALL, after DRAIN, increment chgrp; on chgrp wrap, clear it and increment kngrp; on kngrp wrap, enter DONE, else LOAD_W.
REQ-025 SHALL run passes in order (kn0,ch0),(kn0,ch1),...,(kn1,ch0),...
REQ-026 SHALL assert o_psum_first while STREAM and chgrp==0, and o_psum_last while STREAM and chgrp==num_chgrp-1; both high together when num_chgrp=1.
REQ-027 SHALL hold o_done high only in DONE, for exactly one cycle, then return to IDLE.
REQ-028 SHALL assert o_busy in every state except IDLE.
REQ-029 SHALL ignore i_start outside IDLE and pulse o_err for one cycle without disturbing the job.

Reset
REQ-030 SHALL, with rst low at any time including mid-job, force state IDLE and all outputs, counters and indices to 0 asynchronously.
REQ-031 SHALL start the first job after reset release only on a new i_start.

Configuration
REQ-032 SHALL, with LINE_SCHED_PERF_CNT_EN defined, increment o_stall_cnt each cycle a req is high and its val is low, saturating at 2^32-1 and clearing on accepted i_start.
REQ-033 SHALL, without LINE_SCHED_PERF_CNT_EN, tie o_stall_cnt to 0 and synthesise no counter.

Structure
REQ-034 SHALL take the state encoding, KSIZE, NUM_CHANNEL=3 and NUM_KERNEL=4 from shared package line_sched_pkg.
REQ-035 SHALL use one sub-module, sched_beat_counter (load, enable, terminal-count flag), instanced for weight and data beats.

Verification
REQ-036 SHALL test width=5, ch=1, kn=1, vals held high, start at cycle 0 -> LOAD_W cycles 1-3, STREAM 4-8 with first=last=1, DRAIN 9-10, o_done at 11.
REQ-037 SHALL test width=4, ch=2, kn=2 -> 12 weight beats, 16 data beats, pass order per REQ-025, o_psum_first only in ch0 passes.
REQ-038 SHALL test i_data_val toggling 1,0,1,0 with width=4 -> exactly 4 beats accepted; macro on -> o_stall_cnt=3.
REQ-039 SHALL test width=2 -> o_err pulse, no req ever high, o_done one cycle after start.
REQ-040 SHALL test rst low mid-STREAM -> all outputs 0 at once; the following job completes normally.
REQ-041 SHALL test i_start during LOAD_W -> o_err pulse; job beat counts and indices unchanged.
